frame_loader_ctrl: RTL and testbench

Write-side controller between the UART receiver and the dual-port frame-buffer BRAM. Accepts received bytes (valid strobe, data, frame-error flag), generates the BRAM write address, data and write-enable, and sequences one complete frame per arm request. Provides frame-done, timeout and error status so the host-side logic knows when the buffer holds a coherent image. The BRAM read port is not touched by this block.

---
 rtl/frame_loader_if.sv | 32 +++
 rtl/frame_loader_ctrl.sv | 142 ++++++++++++++
 tb/tb_frame_loader_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_loader_if.sv
// Write-side bus between the UART/host control and the frame loader.
interface frame_loader_if #(
    parameter int unsigned ADDR_W = 19
);
    logic              arm;
    logic              abort;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_frame_error;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_en;
    logic              busy;
    logic              frame_done;
    logic              timeout;
    logic [ADDR_W-1:0] byte_count;
    logic [7:0]        err_count;

    // Host / UART side: drives control and received bytes, observes status.
    modport master (
        output arm, abort, rx_valid, rx_data, rx_frame_error,
        input  wr_addr, wr_data, wr_en, busy, frame_done, timeout,
               byte_count, err_count
    );

    // Loader side.
    modport slave (
        input  arm, abort, rx_valid, rx_data, rx_frame_error,
        output wr_addr, wr_data, wr_en, busy, frame_done, timeout,
               byte_count, err_count
    );
endinterface

// File: rtl/frame_loader_ctrl.sv
// Sequences one received frame into the frame-buffer BRAM write port per arm.
module frame_loader_ctrl #(
    parameter int unsigned ADDR_W           = 19,
    parameter int unsigned FRAME_BYTES      = 307200,
    parameter int unsigned IDLE_TIMEOUT_CYC = 50000
) (
    input  logic           clk,
    input  logic           rst_n,
    frame_loader_if.slave  bus
);

    localparam int unsigned TO_W = $clog2(IDLE_TIMEOUT_CYC + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(IDLE_TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        LOAD       = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0] wr_addr_q,    wr_addr_n;
    logic [7:0]        wr_data_q,    wr_data_n;
    logic              wr_en_q,      wr_en_n;
    logic              busy_q,       busy_n;
    logic              frame_done_q, frame_done_n;
    logic              timeout_q,    timeout_n;
    logic [ADDR_W-1:0] byte_count_q, byte_count_n;
    logic [7:0]        err_count_q,  err_count_n;
    logic [TO_W-1:0]   idle_cnt_q,   idle_cnt_n;
    logic              accept_c;

    // A byte is only usable when it arrived without a stop-bit error.
    assign accept_c = bus.rx_valid && !bus.rx_frame_error;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next-output logic; byte_count doubles as the write address.
    always_comb begin
        state_n      = state;
        wr_addr_n    = wr_addr_q;
        wr_data_n    = wr_data_q;
        wr_en_n      = 1'b0;
        frame_done_n = 1'b0;
        timeout_n    = timeout_q;
        byte_count_n = byte_count_q;
        err_count_n  = err_count_q;
        idle_cnt_n   = idle_cnt_q;

        if (bus.rx_frame_error && (err_count_q != 8'hFF)) begin
            err_count_n = err_count_q + 8'd1;
        end

        if (bus.abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.arm) begin
                        state_n      = WAIT_FIRST;
                        byte_count_n = '0;
                        timeout_n    = 1'b0;
                        idle_cnt_n   = '0;
                    end
                end
                WAIT_FIRST, LOAD: begin
                    if (accept_c) begin
                        wr_en_n      = 1'b1;
                        wr_addr_n    = byte_count_q;
                        wr_data_n    = bus.rx_data;
                        byte_count_n = byte_count_q + ADDR_W'(1);
                        idle_cnt_n   = '0;
                        state_n      = (byte_count_q == LAST_ADDR) ? DONE : LOAD;
                    end else if (state == LOAD) begin
                        if (bus.rx_valid) begin
                            idle_cnt_n = '0;
                        end else if (idle_cnt_q == TO_LAST) begin
                            state_n   = IDLE;
                            timeout_n = 1'b1;
                        end else begin
                            idle_cnt_n = idle_cnt_q + TO_W'(1);
                        end
                    end
                end
                DONE: begin
                    frame_done_n = 1'b1;
                    state_n      = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        busy_n = (state_n == WAIT_FIRST) || (state_n == LOAD);
    end

    // Registered outputs and datapath counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
            byte_count_q <= '0;
            err_count_q  <= '0;
            idle_cnt_q   <= '0;
        end else begin
            wr_addr_q    <= wr_addr_n;
            wr_data_q    <= wr_data_n;
            wr_en_q      <= wr_en_n;
            busy_q       <= busy_n;
            frame_done_q <= frame_done_n;
            timeout_q    <= timeout_n;
            byte_count_q <= byte_count_n;
            err_count_q  <= err_count_n;
            idle_cnt_q   <= idle_cnt_n;
        end
    end

    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.timeout    = timeout_q;
    assign bus.byte_count = byte_count_q;
    assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_frame_loader_ctrl.sv
// Self-checking bench for frame_loader_ctrl with a write scoreboard.
module tb_frame_loader_ctrl;

    localparam int unsigned ADDR_W      = 19;
    localparam int unsigned FRAME_BYTES = 4;
    localparam int unsigned TO_CYC      = 1000;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   fd_seen;
    int   exp_err;
    wr_t  exp_q[$];

    frame_loader_if #(.ADDR_W(ADDR_W)) bus ();

    frame_loader_ctrl #(
        .ADDR_W          (ADDR_W),
        .FRAME_BYTES     (FRAME_BYTES),
        .IDLE_TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock, sample #1 after the edge, score any write seen.
    task automatic step();
        wr_t e;
        @(posedge clk);
        #1;
        if (bus.wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr %0h data %0h, required addr %0h data %0h",
                             bus.wr_addr, bus.wr_data, e.addr, e.data);
                end
            end
        end
        if (bus.frame_done === 1'b1) fd_seen++;
    endtask

    task automatic send(input logic [7:0] d, input logic ferr);
        bus.rx_valid       = 1'b1;
        bus.rx_data        = d;
        bus.rx_frame_error = ferr;
        step();
        bus.rx_valid       = 1'b0;
        bus.rx_frame_error = 1'b0;
    endtask

    task automatic pulse_arm();
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
    endtask

    task automatic pulse_abort();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.wr_addr, bus.wr_data, bus.wr_en, bus.busy, bus.frame_done,
             bus.timeout, bus.byte_count, bus.err_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr %0h data %0h en %b busy %b done %b to %b cnt %0h err %0h, required all 0",
                     bus.wr_addr, bus.wr_data, bus.wr_en, bus.busy, bus.frame_done,
                     bus.timeout, bus.byte_count, bus.err_count);
        end
    endtask

    task automatic test_no_arm();
        send(8'hAB, 1'b0);
        step();
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.byte_count !== '0) begin
            errors++;
            $display("FAIL no_arm: got busy %b cnt %0d, required busy 0 cnt 0", bus.busy, bus.byte_count);
        end
    endtask

    task automatic test_full_frame();
        logic [7:0] d;
        int f0;
        f0 = fd_seen;
        pulse_arm();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_arm: got %b, required 1", bus.busy);
        end
        for (int i = 0; i < 4; i++) begin
            d = 8'((i + 1) * 16);
            exp_q.push_back('{addr: ADDR_W'(i), data: d});
            send(d, 1'b0);
            if (i < 3) begin
                step();
                step();
            end
        end
        checks++;
        if (bus.wr_en !== 1'b1 || bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL last_write_cycle: got en %b done %b busy %b, required 1 0 0",
                     bus.wr_en, bus.frame_done, bus.busy);
        end
        step();
        checks++;
        if (bus.frame_done !== 1'b1 || bus.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_cycle: got done %b en %b, required 1 0", bus.frame_done, bus.wr_en);
        end
        step();
        checks++;
        if (bus.frame_done !== 1'b0 || bus.byte_count !== ADDR_W'(4) || bus.busy !== 1'b0 ||
            fd_seen != f0 + 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL frame_end: got done %b cnt %0d busy %b pulses %0d pending %0d, required 0 4 0 1 0",
                     bus.frame_done, bus.byte_count, bus.busy, fd_seen - f0, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int f0;
        f0 = fd_seen;
        pulse_arm();
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.rx_data = 8'(8'hC0 + i);
            if (i < 4) exp_q.push_back('{addr: ADDR_W'(i), data: 8'(8'hC0 + i)});
            step();
        end
        bus.rx_valid = 1'b0;
        step();
        checks++;
        if (fd_seen != f0 + 1 || exp_q.size() != 0 || bus.byte_count !== ADDR_W'(4)) begin
            errors++;
            $display("FAIL back_to_back: got pulses %0d pending %0d cnt %0d, required 1 0 4",
                     fd_seen - f0, exp_q.size(), bus.byte_count);
        end
    endtask

    task automatic test_timeout();
        int f0;
        f0 = fd_seen;
        pulse_arm();
        exp_q.push_back('{addr: ADDR_W'(0), data: 8'h01});
        send(8'h01, 1'b0);
        exp_q.push_back('{addr: ADDR_W'(1), data: 8'h02});
        send(8'h02, 1'b0);
        for (int i = 0; i < TO_CYC - 1; i++) step();
        checks++;
        if (bus.busy !== 1'b1 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got busy %b timeout %b, required 1 0", bus.busy, bus.timeout);
        end
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.timeout !== 1'b1 || bus.byte_count !== ADDR_W'(2) ||
            fd_seen != f0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_fire: got busy %b timeout %b cnt %0d pulses %0d, required 0 1 2 0",
                     bus.busy, bus.timeout, bus.byte_count, fd_seen - f0);
        end
        step();
        checks++;
        if (bus.timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got %b, required 1", bus.timeout);
        end
        pulse_arm();
        checks++;
        if (bus.timeout !== 1'b0 || bus.busy !== 1'b1 || bus.byte_count !== '0) begin
            errors++;
            $display("FAIL rearm_clear: got timeout %b busy %b cnt %0d, required 0 1 0",
                     bus.timeout, bus.busy, bus.byte_count);
        end
        pulse_abort();
    endtask

    task automatic test_frame_error();
        pulse_arm();
        exp_q.push_back('{addr: ADDR_W'(0), data: 8'h55});
        send(8'h55, 1'b0);
        send(8'h66, 1'b1);
        exp_err++;
        checks++;
        if (bus.wr_en !== 1'b0 || bus.wr_addr !== '0 || bus.byte_count !== ADDR_W'(1) ||
            bus.err_count !== 8'(exp_err) || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_error: got en %b addr %0d cnt %0d err %0d busy %b, required 0 0 1 %0d 1",
                     bus.wr_en, bus.wr_addr, bus.byte_count, bus.err_count, bus.busy, exp_err);
        end
        exp_q.push_back('{addr: ADDR_W'(1), data: 8'h77});
        send(8'h77, 1'b0);
        checks++;
        if (bus.byte_count !== ADDR_W'(2) || exp_q.size() != 0) begin
            errors++;
            $display("FAIL after_error: got cnt %0d pending %0d, required 2 0", bus.byte_count, exp_q.size());
        end
        pulse_abort();
    endtask

    task automatic test_abort();
        int f0;
        f0 = fd_seen;
        pulse_arm();
        exp_q.push_back('{addr: ADDR_W'(0), data: 8'hA1});
        send(8'hA1, 1'b0);
        exp_q.push_back('{addr: ADDR_W'(1), data: 8'hA2});
        send(8'hA2, 1'b0);
        bus.abort = 1'b1;
        bus.arm   = 1'b1;
        send(8'hA3, 1'b0);
        bus.abort = 1'b0;
        bus.arm   = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.byte_count !== ADDR_W'(2) || bus.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL abort: got busy %b cnt %0d en %b, required 0 2 0", bus.busy, bus.byte_count, bus.wr_en);
        end
        step();
        send(8'hA4, 1'b0);
        step();
        checks++;
        if (bus.busy !== 1'b0 || fd_seen != f0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort_arm_ignored: got busy %b pulses %0d pending %0d, required 0 0 0",
                     bus.busy, fd_seen - f0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        pulse_arm();
        exp_q.push_back('{addr: ADDR_W'(0), data: 8'h11});
        send(8'h11, 1'b0);
        exp_q.push_back('{addr: ADDR_W'(1), data: 8'h12});
        send(8'h12, 1'b0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h13;
        #2;
        rst_n = 1'b0;
        #1;
        exp_err = 0;
        checks++;
        if ({bus.wr_addr, bus.wr_data, bus.wr_en, bus.busy, bus.frame_done,
             bus.timeout, bus.byte_count, bus.err_count} !== '0) begin
            errors++;
            $display("FAIL async_reset: got addr %0h data %0h en %b busy %b cnt %0d err %0d, required all 0",
                     bus.wr_addr, bus.wr_data, bus.wr_en, bus.busy, bus.byte_count, bus.err_count);
        end
        step();
        bus.rx_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        send(8'h99, 1'b0);
        send(8'h9A, 1'b0);
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.byte_count !== '0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_idle: got busy %b cnt %0d pending %0d, required 0 0 0",
                     bus.busy, bus.byte_count, exp_q.size());
        end
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        fd_seen            = 0;
        exp_err            = 0;
        rst_n              = 1'b0;
        bus.arm            = 1'b0;
        bus.abort          = 1'b0;
        bus.rx_valid       = 1'b0;
        bus.rx_data        = 8'h00;
        bus.rx_frame_error = 1'b0;
        #1;
        test_reset();
        step();
        step();
        rst_n = 1'b1;
        step();
        test_reset();
        test_no_arm();
        test_full_frame();
        test_back_to_back();
        test_timeout();
        test_frame_error();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
